// File: rtl/note_pkg.sv
// Shared types, widths and period-table helpers for the note_detector decode path.
package note_pkg;

  localparam int unsigned N_NOTES      = 12;
  localparam int unsigned CNT_W        = 24;
  localparam int unsigned NOTE_W       = 4;
  localparam int unsigned OCT_W        = 3;
  localparam int unsigned FULL_W       = 7;
  localparam int unsigned BAND_SLOW_HZ = 107;
  localparam int unsigned BAND_FAST_HZ = 214;

  typedef enum logic [NOTE_W-1:0] {
    NOTE_A, NOTE_BB, NOTE_B, NOTE_C, NOTE_DB, NOTE_D,
    NOTE_EB, NOTE_E, NOTE_F, NOTE_GB, NOTE_G, NOTE_AB
  } note_e;

  typedef enum logic [2:0] {
    ST_ARM, ST_MEAS, ST_NORM, ST_MATCH, ST_PUB
  } state_e;

  // Base-octave note frequencies in Hz; the 13th entry is the next-octave A.
  localparam int unsigned BASE_HZ [N_NOTES+1] = '{
    110, 117, 123, 131, 139, 147, 156, 165, 175, 185, 196, 208, 220
  };

  // Period threshold halfway (in frequency) between note i and note i+1.
  function automatic int unsigned bound(input logic [NOTE_W-1:0] i, input int unsigned clkf);
    longint unsigned num;
    longint unsigned den;
    num = 64'(clkf) << 1;
    den = 64'(BASE_HZ[i]) + 64'(BASE_HZ[NOTE_W'(i + NOTE_W'(1))]);
    return 32'(num / den);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], din};
  end

  assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/note_detector.sv
// Recovers note/octave from a square-wave audio line by edge-to-edge period measurement.
// Build option NOTE_DEBOUNCE_EN: publish only after STABLE_N identical consecutive decodes.
module note_detector
  import note_pkg::*;
#(
  parameter int unsigned CLKF    = 100_000_000,
  parameter int unsigned MAX_OCT = 7,
  parameter int unsigned TIMEOUT = CLKF / 50
`ifdef NOTE_DEBOUNCE_EN
  ,
  parameter int unsigned STABLE_N = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              audio_in,
  output logic              valid,
  output logic [NOTE_W-1:0] note,
  output logic [OCT_W-1:0]  octave,
  output logic [FULL_W-1:0] fullnote,
  output logic              silent,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  TIMEOUT_W = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  P_SLOW    = CNT_W'(CLKF / BAND_SLOW_HZ);
  localparam logic [CNT_W-1:0]  P_FAST    = CNT_W'(CLKF / BAND_FAST_HZ);
  localparam logic [OCT_W-1:0]  OCT_MAX   = OCT_W'(MAX_OCT);
  localparam logic [NOTE_W-1:0] LAST_IDX  = NOTE_W'(N_NOTES - 1);

  state_e            state_q, state_d;
  logic              edge_c;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [OCT_W-1:0]  oct_q, oct_d;
  logic [NOTE_W-1:0] idx_q, idx_d;
  note_e             dec_q, dec_d;
  logic              timeout_c, match_c, done_c, publish_c;
  logic              valid_d, silent_d, busy_d;
  logic [NOTE_W-1:0] note_d;
  logic [OCT_W-1:0]  octave_d;
  logic [FULL_W-1:0] fullnote_d;
  logic [CNT_W-1:0]  bound_tab [N_NOTES];

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (audio_in),
    .rise_c (edge_c)
  );

  // Thresholds fold to constants at elaboration.
  for (genvar g = 0; g < N_NOTES; g++) begin : g_bound
    assign bound_tab[g] = CNT_W'(bound(NOTE_W'(g), CLKF));
  end

  assign timeout_c = (cnt_q >= TIMEOUT_W);
  assign match_c   = (per_q > bound_tab[idx_q]);
  assign done_c    = match_c || (idx_q == LAST_IDX);

  // Period counter restarts on every edge, even while a decode is in flight.
  always_ff @(posedge clk) begin
    if (rst)                    cnt_q <= '0;
    else if (edge_c)            cnt_q <= CNT_W'(1);
    else if (cnt_q < TIMEOUT_W) cnt_q <= cnt_q + CNT_W'(1);
  end

`ifdef NOTE_DEBOUNCE_EN
  localparam int unsigned      REP_W   = $clog2(STABLE_N + 2);
  localparam logic [REP_W-1:0] REP_PUB = REP_W'(STABLE_N);
  localparam logic [REP_W-1:0] REP_SAT = REP_W'(STABLE_N + 1);

  logic [REP_W-1:0] rep_q, rep_next_c;
  note_e            prev_note_q;
  logic [OCT_W-1:0] prev_oct_q;
  logic             same_c;

  // Saturating past STABLE_N keeps an unchanged decode from publishing again.
  always_comb begin
    same_c = (idx_q == prev_note_q) && (oct_q == prev_oct_q);
    if (!same_c)               rep_next_c = REP_W'(1);
    else if (rep_q == REP_SAT) rep_next_c = rep_q;
    else                       rep_next_c = rep_q + REP_W'(1);
    publish_c = (rep_next_c == REP_PUB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q       <= '0;
      prev_note_q <= NOTE_A;
      prev_oct_q  <= '0;
    end else if (state_q == ST_MEAS && timeout_c) begin
      rep_q <= '0;
    end else if (state_q == ST_MATCH && done_c) begin
      rep_q       <= rep_next_c;
      prev_note_q <= note_e'(idx_q);
      prev_oct_q  <= oct_q;
    end
  end
`else
  assign publish_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ARM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARM:   if (edge_c) state_d = ST_MEAS;
      ST_MEAS: begin
        if (timeout_c)   state_d = ST_ARM;
        else if (edge_c) state_d = ST_NORM;
      end
      ST_NORM: begin
        if (per_q > P_SLOW)       state_d = ST_MEAS;
        else if (per_q > P_FAST)  state_d = ST_MATCH;
        else if (oct_q == OCT_MAX) state_d = ST_MEAS;
      end
      ST_MATCH: if (done_c) state_d = publish_c ? ST_PUB : ST_MEAS;
      ST_PUB:   state_d = ST_MEAS;
      default:  state_d = ST_ARM;
    endcase
  end

  // Datapath and output next-values.
  always_comb begin
    per_d      = per_q;
    oct_d      = oct_q;
    idx_d      = idx_q;
    dec_d      = dec_q;
    valid_d    = 1'b0;
    note_d     = note;
    octave_d   = octave;
    fullnote_d = fullnote;
    silent_d   = silent;
    case (state_q)
      ST_MEAS: begin
        if (timeout_c) begin
          silent_d = 1'b1;
          valid_d  = ~silent;
        end else if (edge_c) begin
          per_d = cnt_q;
          oct_d = '0;
          idx_d = '0;
        end
      end
      ST_NORM: begin
        if (per_q <= P_FAST && oct_q != OCT_MAX) begin
          per_d = {per_q[CNT_W-2:0], 1'b0};
          oct_d = oct_q + OCT_W'(1);
        end
      end
      ST_MATCH: begin
        if (done_c) dec_d = note_e'(idx_q);
        else        idx_d = idx_q + NOTE_W'(1);
      end
      ST_PUB: begin
        valid_d    = 1'b1;
        note_d     = dec_q;
        octave_d   = oct_q;
        fullnote_d = FULL_W'(oct_q) * FULL_W'(12) + FULL_W'(dec_q);
        silent_d   = 1'b0;
      end
      default: ;
    endcase
    busy_d = (state_d == ST_NORM) || (state_d == ST_MATCH) || (state_d == ST_PUB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_q <= '0;
      oct_q <= '0;
      idx_q <= '0;
      dec_q <= NOTE_A;
    end else begin
      per_q <= per_d;
      oct_q <= oct_d;
      idx_q <= idx_d;
      dec_q <= dec_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      note     <= '0;
      octave   <= '0;
      fullnote <= '0;
      silent   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      valid    <= valid_d;
      note     <= note_d;
      octave   <= octave_d;
      fullnote <= fullnote_d;
      silent   <= silent_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector at CLKF = 1 MHz, TIMEOUT = 20000 cycles.
module tb_note_detector;

  localparam int unsigned CLKF    = 1_000_000;
  localparam int unsigned TIMEOUT = 20_000;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       audio_in = 1'b0;
  logic       valid;
  logic [3:0] note;
  logic [2:0] octave;
  logic [6:0] fullnote;
  logic       silent;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int half   = 0;

  note_detector #(.CLKF(CLKF), .MAX_OCT(7), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .audio_in (audio_in),
    .valid    (valid),
    .note     (note),
    .octave   (octave),
    .fullnote (fullnote),
    .silent   (silent),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Square wave with period 2*half cycles, starting low; half == 0 holds the line low.
  initial begin : wave_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (half == 0) begin
        audio_in = 1'b0;
        ph = 0;
      end else begin
        ph++;
        if (ph >= half) begin
          ph = 0;
          audio_in = ~audio_in;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) vcount++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    half = 0;
    rst  = 1'b1;
    tick(3);
    rst  = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (note !== 4'd0)     begin errors++; $display("FAIL reset_note: got %0d want 0", note); end
    checks++; if (octave !== 3'd0)   begin errors++; $display("FAIL reset_octave: got %0d want 0", octave); end
    checks++; if (fullnote !== 7'd0) begin errors++; $display("FAIL reset_fullnote: got %0d want 0", fullnote); end
    checks++; if (silent !== 1'b1)   begin errors++; $display("FAIL reset_silent: got %b want 1", silent); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  // 440 Hz: 2272 -> 4544 -> 9088, above bound[0]=8810 -> A, octave 2.
  task automatic test_a440();
    bit got;
    pulse_reset();
    half = 1136;
    wait_valid(8000, got);
    checks++; if (!got)              begin errors++; $display("FAIL a440_valid: got none want pulse within 8000 cycles"); end
    checks++; if (note !== 4'd0)     begin errors++; $display("FAIL a440_note: got %0d want 0", note); end
    checks++; if (octave !== 3'd2)   begin errors++; $display("FAIL a440_octave: got %0d want 2", octave); end
    checks++; if (fullnote !== 7'd24) begin errors++; $display("FAIL a440_fullnote: got %0d want 24", fullnote); end
    checks++; if (silent !== 1'b0)   begin errors++; $display("FAIL a440_silent: got %b want 0", silent); end
  endtask

  // Steady tone: every decode publishes, unless debounce suppresses unchanged repeats.
  task automatic test_back_to_back();
    int v0;
    int want;
`ifdef NOTE_DEBOUNCE_EN
    want = 0;
`else
    want = 1;
`endif
    v0 = vcount;
    tick(3408);
    checks++; if (vcount - v0 != want) begin errors++; $display("FAIL b2b_count: got %0d want %0d", vcount - v0, want); end
    checks++; if (note !== 4'd0)       begin errors++; $display("FAIL b2b_note: got %0d want 0", note); end
    checks++; if (octave !== 3'd2)     begin errors++; $display("FAIL b2b_octave: got %0d want 2", octave); end
    half = 0;
  endtask

  // 261.63 Hz: 3822 -> 7644, in (7407,7874] -> C, octave 1.
  task automatic test_c4();
    bit got;
    pulse_reset();
    half = 1911;
    wait_valid(12000, got);
    checks++; if (!got)               begin errors++; $display("FAIL c4_valid: got none want pulse within 12000 cycles"); end
    checks++; if (note !== 4'd3)      begin errors++; $display("FAIL c4_note: got %0d want 3", note); end
    checks++; if (octave !== 3'd1)    begin errors++; $display("FAIL c4_octave: got %0d want 1", octave); end
    checks++; if (fullnote !== 7'd15) begin errors++; $display("FAIL c4_fullnote: got %0d want 15", fullnote); end
    checks++; if (silent !== 1'b0)    begin errors++; $display("FAIL c4_silent: got %b want 0", silent); end
  endtask

  task automatic test_silence();
    bit got;
    int v0;
    half = 0;
    v0 = vcount;
    wait_valid(25000, got);
    checks++; if (!got)               begin errors++; $display("FAIL silence_valid: got none want pulse within 25000 cycles"); end
    checks++; if (silent !== 1'b1)    begin errors++; $display("FAIL silence_silent: got %b want 1", silent); end
    checks++; if (note !== 4'd3)      begin errors++; $display("FAIL silence_note: got %0d want 3", note); end
    checks++; if (octave !== 3'd1)    begin errors++; $display("FAIL silence_octave: got %0d want 1", octave); end
    checks++; if (fullnote !== 7'd15) begin errors++; $display("FAIL silence_fullnote: got %0d want 15", fullnote); end
    tick(500);
    checks++; if (vcount - v0 != 1)   begin errors++; $display("FAIL silence_pulses: got %0d want 1", vcount - v0); end
  endtask

  // 50 Hz: period 20000 meets the timeout; already silent, so nothing publishes.
  task automatic test_slow();
    int v0;
    v0 = vcount;
    half = 10000;
    tick(30100);
    checks++; if (vcount != v0)    begin errors++; $display("FAIL slow_pulses: got %0d want 0", vcount - v0); end
    checks++; if (silent !== 1'b1) begin errors++; $display("FAIL slow_silent: got %b want 1", silent); end
    checks++; if (note !== 4'd3)   begin errors++; $display("FAIL slow_note: got %0d want 3", note); end
    half = 0;
  endtask

  // 100 kHz: period 10 never leaves the fast side after 7 shifts (1280 <= 4672).
  task automatic test_too_fast();
    int v0;
    v0 = vcount;
    half = 5;
    tick(300);
    checks++; if (vcount != v0)    begin errors++; $display("FAIL fast_pulses: got %0d want 0", vcount - v0); end
    checks++; if (silent !== 1'b1) begin errors++; $display("FAIL fast_silent: got %b want 1", silent); end
    half = 0;
  endtask

  task automatic test_reset_mid_match();
    bit got;
    bit seen;
    pulse_reset();
    half = 1911;
    wait_valid(12000, got);
    checks++; if (!got) begin errors++; $display("FAIL mid_first_valid: got none want pulse within 12000 cycles"); end
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_busy: got busy=0 want busy=1 within 5000 cycles"); end
    // Two NORM cycles, then into the 4-step match for C.
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL mid_valid: got %b want 0", valid); end
    checks++; if (note !== 4'd0)     begin errors++; $display("FAIL mid_note: got %0d want 0", note); end
    checks++; if (octave !== 3'd0)   begin errors++; $display("FAIL mid_octave: got %0d want 0", octave); end
    checks++; if (fullnote !== 7'd0) begin errors++; $display("FAIL mid_fullnote: got %0d want 0", fullnote); end
    checks++; if (silent !== 1'b1)   begin errors++; $display("FAIL mid_silent: got %b want 1", silent); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy_clear: got %b want 0", busy); end
    tick(2);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_armed: got busy=%b want 0", busy); end
    half = 0;
  endtask

  initial begin
    test_reset();
    test_a440();
    test_back_to_back();
    test_c4();
    test_silence();
    test_slow();
    test_too_fast();
    test_reset_mid_match();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_detector.md
Name: note_detector

Overview:
- Decoder counterpart to the musicbox tone generator: receives a 1-bit square-wave audio line and recovers the played note.
- Measures the rising-edge-to-rising-edge period in clk cycles, normalizes it into the base octave (A110..Ab208), then classifies it against 12 period thresholds.
- Publishes note (0=A..11=Ab), octave and fullnote = octave*12+note, the same encoding the song ROMs use.
- Sits between a PMOD audio input (or loop-back of j0) and display/scoring logic.

Parameters:
- CLKF, 100_000_000, clk frequency in Hz; all period constants derive from it.
- MAX_OCT, 7, highest octave reported; faster tones are discarded.
- TIMEOUT, CLKF/50, cycles with no rising edge before silence is declared.
- STABLE_N, 2, consecutive identical decodes needed to publish (debounce feature only).

Ports:
- clk  in  1  system clock, CLKF Hz
- rst  in  1  synchronous, active-high reset
- audio_in  in  1  asynchronous square-wave input
- valid  out  1  one-cycle pulse: note/octave/fullnote/silent updated
- note  out  4  0..11, A..Ab
- octave  out  3  0..MAX_OCT
- fullnote  out  7  octave*12+note
- silent  out  1  1 = no tone detected
- busy  out  1  1 while in NORM/MATCH/PUB

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: valid=0, note=0, octave=0, fullnote=0, silent=1, busy=0; FSM=ARM; counters cleared.
- Input sync: audio_in passes through a 2-flop synchronizer. A rising edge is detected on the synced signal against a third flop; edge-to-state latency is 3 cycles.
- Period counter: 24 bits. Clears to 1 on each rising edge, otherwise increments, saturating at TIMEOUT.
- FSM states:
  - ARM: wait for the first edge. Counter starts; no period yet. Next state: MEAS.
  - MEAS: on an edge, latch P = counter and oct = 0, go to NORM. If the counter reaches TIMEOUT: set silent=1, pulse valid once (only if silent was 0), go to ARM.
  - NORM: one step per cycle.
    - P > CLKF/107 (slower than the A110 band): discard, go to MEAS.
    - P > CLKF/214: go to MATCH.
    - oct == MAX_OCT: discard (too fast), go to MEAS.
    - Otherwise P <<= 1, oct += 1.
  - MATCH: i counts 0..11, one per cycle. Bound[i] = CLKF*2/(f_i + f_(i+1)), using f = 110,117,123,131,139,147,156,165,175,185,196,208 and f_12 = 220.
    - If P > Bound[i], latch note=i and go to PUB.
    - i=11 and no match: note=11.
  - PUB: one cycle. Update outputs, pulse valid, set silent=0. Go to MEAS.
- Worst-case decode latency: 1+7+12+1 = 21 cycles after the edge latch.
- Edges during NORM/MATCH/PUB: the counter still restarts on the edge. That period's measurement is lost; the next one is used.
- Outputs hold their values between valid pulses. valid also pulses on the transition into silence.
- rst mid-decode: abandon immediately, restore reset values.
- Bounds are compared at 24-bit width. Shifting cannot overflow, because shifting stops once P > CLKF/214.

Optional Feature:
- Macro: NOTE_DEBOUNCE_EN.
- Defined: the decoded (note, octave) is compared with the previous decode. A match counter increments; a mismatch reloads it to 1. PUB occurs only when the counter reaches STABLE_N, and repeats are not re-published while the decode is unchanged. Silence resets the counter.
- Undefined: every successful decode publishes.

Decomposition:
- Package note_pkg:
  - note enum A..Ab
  - table of 12 base frequencies
  - function bound(i, clkf)
  - FSM state typedef
  - constants for the 107/214 Hz band edges
- Sub-module edge_sync: 2-flop synchronizer plus rising-edge pulse.
- Threshold lookup stays inside note_detector.

Test Plan (CLKF=1_000_000, TIMEOUT=20_000):
- 440 Hz square, period 2272 -> shifts 4544, 9088; valid with note=0, octave=2, fullnote=24, silent=0.
- 261.63 Hz (period 3822) -> 7644 in (7407,7874]: note=3, octave=1, fullnote=15.
- Tone, then audio_in held low 20_000 cycles -> single valid pulse, silent=1; note/octave retain their last values.
- 50 Hz (period 20_000 or more) -> silence path, no note published.
- 100 kHz (period 10) -> discarded after 7 shifts, no valid.
- rst asserted mid-MATCH for 1 cycle -> all outputs at reset values next cycle; FSM in ARM. With NOTE_DEBOUNCE_EN, alternating A/C periods -> no valid; 2 A periods -> one valid.
